// File: rtl/sm_rom_loader.sv
// sm_rom_loader: turns a byte stream into 32-bit instruction-memory writes.
// Stream format: 2-byte little-endian word count, then 4 little-endian bytes per word.
// The CPU is held in reset from start until the load completes.
// Build option SM_ROM_LOADER_CSUM_EN: a trailing checksum byte must make the
// modulo-256 sum of all data bytes come to zero.
module sm_rom_loader #(
    parameter int unsigned SIZE  = 64,
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
        StDone,
        StErr
`ifdef SM_ROM_LOADER_CSUM_EN
        ,
        StCsum
`endif
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] length;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] word_cnt;
`ifdef SM_ROM_LOADER_CSUM_EN
    logic [7:0]       sum;
`endif

    logic             xfer;
    logic [LEN_W-1:0] len_full;
    logic             last_word;

    // Transfer handshake and header/word-count decode helpers
    always_comb begin
        xfer      = in_valid && in_ready;
        len_full  = {in_data, length[7:0]};
        last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == length;
    end

    // Loader FSM; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b0;
            we        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            cpu_rst_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            length    <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
`ifdef SM_ROM_LOADER_CSUM_EN
            sum       <= '0;
`endif
        end else begin
            we <= 1'b0;
            unique case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state     <= StLen0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                        done      <= 1'b0;
                        err       <= 1'b0;
`ifdef SM_ROM_LOADER_CSUM_EN
                        sum       <= '0;
`endif
                    end
                end
                StLen0: begin
                    if (xfer) begin
                        length[7:0] <= in_data;
                        state       <= StLen1;
                    end
                end
                StLen1: begin
                    if (xfer) begin
                        length <= len_full;
                        if (len_full == '0) begin
`ifdef SM_ROM_LOADER_CSUM_EN
                            // Empty image still carries a checksum byte
                            state     <= StCsum;
`else
                            state     <= StDone;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
`endif
                        end else if (len_full > LEN_W'(SIZE)) begin
                            // Reject before any write; CPU stays in reset
                            state    <= StErr;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state    <= StData;
                            wa       <= '0;
                            byte_cnt <= '0;
                            word_cnt <= '0;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        wd[{byte_cnt, 3'b000} +: 8] <= in_data;
                        byte_cnt                    <= byte_cnt + 2'd1;
`ifdef SM_ROM_LOADER_CSUM_EN
                        sum                         <= sum + in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            state    <= StWrite;
                            in_ready <= 1'b0;
                            we       <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    word_cnt <= word_cnt + CNT_W'(1);
                    if (last_word) begin
                        // wa is left on the final word so it never reaches SIZE
`ifdef SM_ROM_LOADER_CSUM_EN
                        state     <= StCsum;
                        in_ready  <= 1'b1;
`else
                        state     <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
`endif
                    end else begin
                        wa       <= wa + 32'd1;
                        state    <= StData;
                        in_ready <= 1'b1;
                    end
                end
`ifdef SM_ROM_LOADER_CSUM_EN
                StCsum: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (sum + in_data == 8'h00) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            // Words stay written; CPU is kept in reset
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_rom_loader.sv
// tb_sm_rom_loader: directed self-checking bench for sm_rom_loader.
// Honours SM_ROM_LOADER_CSUM_EN by appending checksum bytes to each stream.
module tb_sm_rom_loader;

    localparam int unsigned SIZE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    int rst_leak = 0;

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [7:0]  stream[$];

    sm_rom_loader #(
        .SIZE  (SIZE),
        .LEN_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Record every write and flag any busy cycle where the CPU was not in reset
    always @(negedge clk) begin
        if (we) begin
            wq_a.push_back(wa);
            wq_d.push_back(wd);
        end
        if (busy && cpu_rst_n) rst_leak++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte after `stall` idle cycles; returns at the negedge after the transfer
    task automatic send_byte(input logic [7:0] b, input int stall);
        int n;
        for (int i = 0; i < stall; i++) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input int stall);
        foreach (stream[i]) send_byte(stream[i], stall);
    endtask

    // Full session body; returns at the first negedge in DONE for a good stream
    task automatic load(input int stall);
        logic [15:0] len;
`ifdef SM_ROM_LOADER_CSUM_EN
        logic [7:0]  s;
`endif
        len = {stream[1], stream[0]};
        send_stream(stall);
`ifdef SM_ROM_LOADER_CSUM_EN
        s = 8'h00;
        for (int i = 2; i < stream.size(); i++) s = s + stream[i];
        send_byte(8'h00 - s, stall);
`else
        if (len != 16'd0) begin
            check("we_on_last_write", {31'd0, we}, 32'd1);
            check("cpu_rst_held_in_write", {31'd0, cpu_rst_n}, 32'd0);
            @(negedge clk);
        end
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, we}, 32'd0);
        check({tag, "_wa"}, wa, 32'd0);
        check({tag, "_wd"}, wd, 32'd0);
        check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic check_basic_writes(input string tag);
        check({tag, "_nwrites"}, wq_a.size(), 32'd2);
        if (wq_a.size() == 2) begin
            check({tag, "_wa0"}, wq_a[0], 32'd0);
            check({tag, "_wd0"}, wq_d[0], 32'h0010_0513);
            check({tag, "_wa1"}, wq_a[1], 32'd1);
            check({tag, "_wd1"}, wq_d[1], 32'h0020_0593);
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_d;

        // Reset state
        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // Basic load
        wq_a.delete();
        wq_d.delete();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        do_start();
        check("len0_in_ready", {31'd0, in_ready}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd1);
        check("len0_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        load(0);
        check_basic_writes("basic");

        // Same stream with 5-cycle gaps between bytes
        wq_a.delete();
        wq_d.delete();
        rst_leak = 0;
        do_start();
        check("restart_done_cleared", {31'd0, done}, 32'd0);
        load(5);
        check_basic_writes("stall");
        check("stall_cpu_rst_leak", rst_leak, 32'd0);

        // Oversize header is rejected without writes
        wq_a.delete();
        wq_d.delete();
        stream = '{8'h41, 8'h00};
        do_start();
        send_stream(0);
        check("over_err", {31'd0, err}, 32'd1);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_busy", {31'd0, busy}, 32'd0);
        check("over_in_ready", {31'd0, in_ready}, 32'd0);
        check("over_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("over_still_err", {31'd0, err}, 32'd1);
        check("over_nwrites", wq_a.size(), 32'd0);

        // Empty image after an error
        stream = '{8'h00, 8'h00};
        do_start();
        check("zero_err_cleared", {31'd0, err}, 32'd0);
        load(0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_err", {31'd0, err}, 32'd0);
        check("zero_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("zero_nwrites", wq_a.size(), 32'd0);

        // Full depth: 64 words, byte i carries value i
        wq_a.delete();
        wq_d.delete();
        stream = '{8'h40, 8'h00};
        for (int i = 0; i < 256; i++) stream.push_back(8'(i));
        do_start();
        load(0);
        check("full_nwrites", wq_a.size(), 32'd64);
        if (wq_a.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                exp_d = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
                check($sformatf("full_wa%0d", k), wq_a[k], 32'(k));
                check($sformatf("full_wd%0d", k), wq_d[k], exp_d);
            end
        end
        check("full_done", {31'd0, done}, 32'd1);

        // Reset after 6 data bytes: one write, then everything back to reset values
        wq_a.delete();
        wq_d.delete();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_start();
        send_stream(0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_nwrites", wq_a.size(), 32'd1);
        if (wq_a.size() == 1) begin
            check("midrst_wa0", wq_a[0], 32'd0);
            check("midrst_wd0", wq_d[0], 32'h4433_2211);
        end
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);

`ifdef SM_ROM_LOADER_CSUM_EN
        // Checksum accepted: 01+02+03+04 = 0A, 0A+F6 = 00
        wq_a.delete();
        wq_d.delete();
        stream = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        do_start();
        send_stream(0);
        send_byte(8'hF6, 0);
        check("csum_ok_done", {31'd0, done}, 32'd1);
        check("csum_ok_err", {31'd0, err}, 32'd0);
        check("csum_ok_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("csum_ok_wd", (wq_d.size() == 1) ? wq_d[0] : 32'hxxxx_xxxx, 32'h0403_0201);

        // Checksum rejected, word still written
        wq_a.delete();
        wq_d.delete();
        do_start();
        send_stream(0);
        send_byte(8'hF5, 0);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
        check("csum_bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("csum_bad_nwrites", wq_a.size(), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
